rom_memory_sequencer: RTL and testbench

- Parametrised successor to the byte-wide synthesis ROM.
- Provides byte, halfword and word loads, little-endian, from a byte-addressed ROM.
- Uses a valid/ready request/response handshake and assembles one byte per clock.
- Sits between the CPU load/fetch path and program storage; contents are loaded by the top module or bench (hierarchical $readmemh into array rom).

---
 rtl/rom_pkg.sv | 37 +++
 rtl/rom_byte_array.sv | 15 +
 rtl/rom_memory_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rom_memory_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and helpers for the ROM load sequencer.
// The optional misalignment trap (macro ROM_MISALIGN_TRAP_EN) lives in rom_memory_sequencer.sv.
package rom_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        RESP  = 2'b10
    } state_e;

    // Number of bytes moved by an access; reserved size yields 0.
    function automatic logic [2:0] nbytes(size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    // Zero- or sign-extend the assembled little-endian bytes to 32 bits.
    function automatic logic [31:0] extend_load(logic [31:0] raw, size_e size, logic sgn);
        case (size)
            SIZE_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
            SIZE_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
            default:   return raw;
        endcase
    endfunction

endpackage

// File: rtl/rom_byte_array.sv
// Byte-addressed ROM storage with a combinational read port.
// Contents are preloaded from outside through the array named rom.
module rom_byte_array #(
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW = $clog2(4 * DEPTH)
) (
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] rom [4 * DEPTH];

    assign rd_data_o = rom[rd_addr_i];

endmodule

// File: rtl/rom_memory_sequencer.sv
// Byte/half/word little-endian load sequencer over a byte-wide ROM.
// Requests use valid/ready; one byte is fetched per clock and the result is
// extended and held in RESP until the consumer accepts it.
// Optional: define ROM_MISALIGN_TRAP_EN to turn misaligned half/word loads into errors.
module rom_memory_sequencer
    import rom_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_error
);

    localparam int unsigned BYTE_AW = $clog2(4 * DEPTH);
    localparam logic [ADDR_WIDTH:0] BYTE_CAP = (ADDR_WIDTH + 1)'(4 * DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    size_e                 size_q, size_d;
    logic                  signed_q, signed_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           data_q, data_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  resp_error_q, resp_error_d;

    logic [BYTE_AW-1:0]    rd_addr;
    logic [7:0]            rd_data;
    size_e                 req_size_e;
    logic [ADDR_WIDTH:0]   last_addr;
    logic                  misalign;
    logic                  req_bad;
    logic [31:0]           fetch_data;

    // Legal accesses never exceed the byte capacity, so truncation is safe.
    assign rd_addr = BYTE_AW'(addr_q + ADDR_WIDTH'(cnt_q));

    rom_byte_array #(
        .DEPTH (DEPTH)
    ) u_rom (
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Request legality: computed one bit wider than the address so it cannot wrap.
    always_comb begin
        req_size_e = size_e'(req_size);
        last_addr  = {1'b0, req_address} + (ADDR_WIDTH + 1)'(nbytes(req_size_e))
                     - (ADDR_WIDTH + 1)'(1);
`ifdef ROM_MISALIGN_TRAP_EN
        misalign = ((req_size_e == SIZE_HALF) && req_address[0]) ||
                   ((req_size_e == SIZE_WORD) && (req_address[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_bad = (req_size_e == SIZE_RSVD) || (last_addr >= BYTE_CAP) || misalign;
    end

    // Next-state and registered-output logic for the IDLE/FETCH/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;

        fetch_data = data_q;
        fetch_data[8 * cnt_q[1:0] +: 8] = rd_data;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d       = req_address;
                    size_d       = req_size_e;
                    signed_d     = req_signed;
                    cnt_d        = 3'd0;
                    data_d       = 32'd0;
                    resp_data_d  = 32'd0;
                    resp_error_d = 1'b0;
                    req_ready_d  = 1'b0;
                    if (req_bad) begin
                        resp_error_d = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                data_d = fetch_data;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_d == nbytes(size_q)) begin
                    resp_data_d  = extend_load(fetch_data, size_q, signed_q);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            cnt_q        <= 3'd0;
            data_q       <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_rom_memory_sequencer.sv
// Self-checking bench for rom_memory_sequencer: directed vector table, hand-written
// backpressure and reset sequences, and random loads checked against a byte-array model.
// Expectations follow ROM_MISALIGN_TRAP_EN when it is defined.
module tb_rom_memory_sequencer;

    localparam int DEPTH = 64;
    localparam int CAP   = 4 * DEPTH;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [CAP];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    rom_memory_sequencer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_error  (resp_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: load value computed directly from the byte array and the access rules.
    function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic sgn, output logic [31:0] data,
                                  output logic err, output int lat);
        int nb;
        err  = 1'b0;
        data = 32'd0;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd3) err = 1'b1;
        else if (longint'(addr) + longint'(nb) > longint'(CAP)) err = 1'b1;
`ifdef ROM_MISALIGN_TRAP_EN
        if (size != 2'd3 && (addr % nb) != 0) err = 1'b1;
`endif
        if (!err) begin
            for (int i = 0; i < nb; i++)
                data = data | (32'(mem[int'(addr) + i]) << (8 * i));
            if (sgn && nb < 4 && data[8 * nb - 1])
                data = data | ~((32'h1 << (8 * nb)) - 32'h1);
        end
        lat = err ? 0 : nb;
    endfunction

    // One complete transaction: accept, wait for response, optional backpressure, handshake.
    // Latency counts clock edges after the accept edge; an error response is registered
    // at the accept edge itself.
    task automatic run_req(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input int hold, input logic [31:0] exp_d,
                           input logic exp_e, input int exp_lat);
        int lat;
        @(negedge clock);
        check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_address = addr;
        req_size    = size;
        req_signed  = sgn;
        resp_ready  = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, resp_data, exp_d);
        check({tag, " error"}, 32'(resp_error), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s hold%0d valid", tag, i), 32'(resp_valid), 32'd1);
            check($sformatf("%s hold%0d data", tag, i), resp_data, exp_d);
            check($sformatf("%s hold%0d error", tag, i), 32'(resp_error), 32'(exp_e));
            check($sformatf("%s hold%0d req_ready", tag, i), 32'(req_ready), 32'd0);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check({tag, " post_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " post_ready"}, 32'(req_ready), 32'd1);
        check({tag, " post_data_kept"}, resp_data, exp_d);
    endtask

    initial begin
        logic [31:0] ed;
        logic        ee;
        int          el;
        logic [31:0] ra;
        logic [1:0]  rs;
        logic        rg;
        int          sel;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_address = 32'd0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        resp_ready  = 1'b0;

        for (int i = 0; i < CAP; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'h9A; mem[5] = 8'h80;
        mem[CAP-4] = 8'hDE; mem[CAP-3] = 8'hAD; mem[CAP-2] = 8'hBE; mem[CAP-1] = 8'hEF;
        for (int i = 0; i < CAP; i++) dut.u_rom.rom[i] = mem[i];

        vecs[0]  = '{32'h0,       2'd2, 1'b0, 32'h12345678, 1'b0, 4};
        vecs[1]  = '{32'h5,       2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1};
        vecs[2]  = '{32'h5,       2'd0, 1'b0, 32'h00000080, 1'b0, 1};
        vecs[3]  = '{32'(CAP-4),  2'd2, 1'b0, 32'hEFBEADDE, 1'b0, 4};
        vecs[4]  = '{32'(CAP-2),  2'd2, 1'b0, 32'h0,        1'b1, 0};
        vecs[5]  = '{32'hFFFFFFFF, 2'd2, 1'b0, 32'h0,       1'b1, 0};
        vecs[6]  = '{32'h0,       2'd3, 1'b0, 32'h0,        1'b1, 0};
        vecs[7]  = '{32'(CAP-2),  2'd1, 1'b0, 32'h0000EFBE, 1'b0, 2};
        vecs[8]  = '{32'(CAP-1),  2'd0, 1'b1, 32'hFFFFFFEF, 1'b0, 1};
        vecs[9]  = '{32'(CAP-1),  2'd1, 1'b0, 32'h0,        1'b1, 0};
`ifdef ROM_MISALIGN_TRAP_EN
        vecs[10] = '{32'h3,       2'd1, 1'b1, 32'h0,        1'b1, 0};
        vecs[11] = '{32'h1,       2'd2, 1'b0, 32'h0,        1'b1, 0};
`else
        vecs[10] = '{32'h3,       2'd1, 1'b1, 32'hFFFF9A12, 1'b0, 2};
        vecs[11] = '{32'h1,       2'd2, 1'b0, 32'h9A123456, 1'b0, 4};
`endif

        // Reset values while reset is held.
        #12;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_error", 32'(resp_error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 12; v++)
            run_req($sformatf("vec%0d", v), vecs[v].addr, vecs[v].size, vecs[v].sgn, 0,
                    vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat);

        // Long backpressure on a good response and on an error response.
        run_req("bp_word", 32'h0, 2'd2, 1'b0, 10, 32'h12345678, 1'b0, 4);
        run_req("bp_err", 32'(CAP), 2'd0, 1'b0, 3, 32'h0, 1'b1, 0);

        // Reset in the middle of a word fetch.
        @(negedge clock);
        req_valid   = 1'b1;
        req_address = 32'h0;
        req_size    = 2'd2;
        req_signed  = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("midfetch not_valid", 32'(resp_valid), 32'd0);
        check("midfetch busy", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("midreset resp_valid", 32'(resp_valid), 32'd0);
        check("midreset req_ready", 32'(req_ready), 32'd1);
        check("midreset resp_data", resp_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_req("post_reset", 32'h0, 2'd2, 1'b0, 0, 32'h12345678, 1'b0, 4);

        // Randomized loads against the model.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 32'($urandom_range(0, CAP - 1));
            else if (sel == 7) ra = 32'($urandom_range(CAP - 4, CAP + 3));
            else if (sel == 8) ra = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            else               ra = $urandom;
            rs = 2'($urandom_range(0, 3));
            rg = 1'($urandom);
            model(ra, rs, rg, ed, ee, el);
            run_req($sformatf("rnd%0d", n), ra, rs, rg, $urandom_range(0, 2), ed, ee, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
